// File: rtl/acumulador_csa.sv
`default_nettype none
// ============================================================================
// Module   : acumulador_csa
// Summary  : Carry-save accumulator; one CSA step per operand handshake,
//            with a single carry-propagate add before the result is presented.
// Revision : 1.0 - initial release
// ============================================================================
module acumulador_csa #(
  parameter int W = 4,
  parameter int G = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       count_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     operand_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W+G-1:0]   result_o,
  output logic             busy_o
);

  localparam int R = W + G;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACC     = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [R-1:0]   s_q, s_d;
  logic [R-1:0]   c_q, c_d;
  logic [3:0]     rem_q, rem_d;
  logic [R-1:0]   result_q, result_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [R-1:0]   x_w;
  logic [R-1:0]   csa_sum_w;
  logic [R-1:0]   csa_carry_w;

  assign x_w         = {{G{1'b0}}, operand_i};
  assign csa_sum_w   = s_q ^ c_q ^ x_w;
  assign csa_carry_w = ((s_q & c_q) | (s_q & x_w) | (c_q & x_w)) << 1;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    rem_d    = rem_q;
    result_d = result_q;

    if (clr_i) begin
      state_d = S_IDLE;
      s_d     = '0;
      c_d     = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (count_i == 4'd0) begin
              result_d = '0;
              state_d  = S_DONE;
            end else begin
              s_d     = '0;
              c_d     = '0;
              rem_d   = count_i;
              state_d = S_ACC;
            end
          end
        end
        S_ACC: begin
          if (in_valid_i) begin
            s_d   = csa_sum_w;
            c_d   = csa_carry_w;
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) state_d = S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          // Single carry-propagate add; wraps naturally at R bits.
          result_d = s_q + c_q;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_ready_d  = (state_d == S_ACC);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      s_q         <= '0;
      c_q         <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_csa.sv
`default_nettype none
// ============================================================================
// Module   : tb_acumulador_csa
// Summary  : Scoreboard bench for acumulador_csa; expected sums queued at start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acumulador_csa;

  localparam int W = 4;
  localparam int G = 4;

  logic           clk;
  logic           rst_n;
  logic           start_i;
  logic [3:0]     count_i;
  logic           clr_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [W-1:0]   operand_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [W+G-1:0] result_o;
  logic           busy_o;

  int checks;
  int errors;
  logic [7:0] exp_q[$];
  logic [3:0] ops[0:15];
  logic [7:0] last_res;

  acumulador_csa #(.W(W), .G(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .count_i    (count_i),
    .clr_i      (clr_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .operand_i  (operand_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction: n operands, gap idle cycles before each, hold DONE cycles with out_ready low.
  task automatic do_txn(input int n, input int gap, input int hold);
    logic [7:0] sum;
    logic [7:0] exp_v;
    sum = 8'h00;
    @(negedge clk);
    start_i = 1'b1;
    count_i = n[3:0];
    for (int i = 0; i < n; i++) sum = sum + {4'h0, ops[i]};
    exp_q.push_back(sum);
    @(negedge clk);
    start_i = 1'b0;
    if (n == 0) begin
      checks++;
      if (out_valid_o !== 1'b1) begin
        errors++; $display("FAIL zero_latency: out_valid=%b expected 1", out_valid_o);
      end
      checks++;
      if (in_ready_o !== 1'b0) begin
        errors++; $display("FAIL zero_in_ready: in_ready=%b expected 0", in_ready_o);
      end
    end else begin
      checks++;
      if (in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
        errors++; $display("FAIL acc_entry: in_ready=%b busy=%b expected 1 1", in_ready_o, busy_o);
      end
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < gap; g++) begin
          in_valid_i = 1'b0;
          operand_i  = 4'($urandom);
          @(negedge clk);
          checks++;
          if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL gap_in_ready: in_ready=%b expected 1", in_ready_o);
          end
        end
        in_valid_i = 1'b1;
        operand_i  = ops[i];
        @(negedge clk);
        in_valid_i = 1'b0;
        operand_i  = 4'($urandom);
      end
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++; $display("FAIL resolve_cycle: out_valid=%b in_ready=%b busy=%b expected 0 0 1",
                           out_valid_o, in_ready_o, busy_o);
      end
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1) begin
        errors++; $display("FAIL latency: out_valid=%b expected 1", out_valid_o);
      end
    end
    for (int h = 0; h < hold; h++) begin
      start_i = h[0];
      count_i = 4'd0;
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== exp_q[0]) begin
        errors++; $display("FAIL hold_stable: out_valid=%b result=%h expected 1 %h",
                           out_valid_o, result_o, exp_q[0]);
      end
    end
    start_i = 1'b0;
    exp_v = exp_q.pop_front();
    last_res = exp_v;
    checks++;
    if (result_o !== exp_v) begin
      errors++; $display("FAIL result: got %h expected %h", result_o, exp_v);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL release: out_valid=%b busy=%b expected 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (result_o !== 8'h00 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_state: result=%h ov=%b ir=%b busy=%b expected 00 0 0 0",
                         result_o, out_valid_o, in_ready_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    ops[0] = 4'b1011; ops[1] = 4'b1101; ops[2] = 4'b0110;
    do_txn(3, 0, 0);
    checks++;
    if (last_res !== 8'h1E) begin
      errors++; $display("FAIL b2b_model: got %h expected 1e", last_res);
    end
  endtask

  task automatic test_gaps();
    ops[0] = 4'b1111; ops[1] = 4'b1111; ops[2] = 4'b0111;
    do_txn(3, 2, 0);
  endtask

  task automatic test_max();
    for (int i = 0; i < 15; i++) ops[i] = 4'hF;
    do_txn(15, 0, 0);
  endtask

  task automatic test_zero_count();
    do_txn(0, 0, 0);
  endtask

  task automatic test_backpressure();
    ops[0] = 4'h9; ops[1] = 4'h8;
    do_txn(2, 1, 5);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_i = 1'b1; count_i = 4'd4;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1; operand_i = 4'hA;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result_o !== 8'h00 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: result=%h ov=%b ir=%b busy=%b expected 00 0 0 0",
                         result_o, out_valid_o, in_ready_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL no_partial: out_valid=%b busy=%b expected 0 0", out_valid_o, busy_o);
    end
    ops[0] = 4'h3; ops[1] = 4'h4;
    do_txn(2, 0, 0);
    checks++;
    if (last_res !== 8'h07) begin
      errors++; $display("FAIL post_reset_model: got %h expected 07", last_res);
    end
  endtask

  task automatic test_clr();
    logic [7:0] held;
    held = result_o;
    @(negedge clk);
    start_i = 1'b1; count_i = 4'd3;
    @(negedge clk);
    start_i = 1'b0;
    in_valid_i = 1'b1; operand_i = 4'h7;
    @(negedge clk);
    clr_i = 1'b1; start_i = 1'b1; count_i = 4'd0;
    @(negedge clk);
    clr_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || result_o !== held) begin
      errors++; $display("FAIL clr_acc: busy=%b ir=%b ov=%b result=%h expected 0 0 0 %h",
                         busy_o, in_ready_o, out_valid_o, result_o, held);
    end
    @(negedge clk);
    start_i = 1'b1; count_i = 4'd0;
    @(negedge clk);
    start_i = 1'b0;
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 8'h00) begin
      errors++; $display("FAIL clr_done: ov=%b busy=%b result=%h expected 0 0 00",
                         out_valid_o, busy_o, result_o);
    end
    ops[0] = 4'h5; ops[1] = 4'h6;
    do_txn(2, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) ops[i] = 4'($urandom);
      do_txn(n, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    checks = 0; errors = 0; last_res = 8'h00;
    start_i = 1'b0; count_i = 4'd0; clr_i = 1'b0; in_valid_i = 1'b0;
    operand_i = '0; out_ready_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_max();
    test_zero_count();
    test_backpressure();
    test_reset_mid();
    test_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acumulador_csa.md
ACUMULADOR_CSA -- requirements
Module: acumulador_csa

Interface
REQ-001 Parameter W, 4, operand width in bits.
REQ-002 Parameter G, 4, guard bits; result width R = W+G.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  start request; sampled only in IDLE.
REQ-006 count  input  4  number of operands to accumulate (0..15, unsigned); sampled with start.
REQ-007 clr  input  1  synchronous abort; returns FSM to IDLE.
REQ-008 in_valid  input  1  operand valid.
REQ-009 in_ready  output  1  block accepts operand.
REQ-010 operand  input  W  operand value, unsigned.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  R  final sum, unsigned.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACC, RESOLVE, DONE; one-hot or binary encoding is free.
REQ-016 IDLE with start=1 and count=0 SHALL load result=0 and go to DONE next cycle.
REQ-017 IDLE with start=1 and count>0 SHALL clear S and C (R bits each), load rem=count, go to ACC.
REQ-018 start SHALL be ignored in all states other than IDLE.
REQ-019 in_ready SHALL be 1 only in ACC; handshake = in_valid & in_ready.
REQ-020 Each handshake SHALL perform one carry-save step with X = zero-extended operand: S <= S^C^X; C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to R bits; rem <= rem-1.
REQ-021 Handshake with rem=1 SHALL move FSM to RESOLVE; in_valid low in ACC SHALL hold all state.
REQ-022 RESOLVE SHALL last exactly one cycle: result <= (S+C) mod 2^R, then go to DONE.
REQ-023 DONE SHALL drive out_valid=1 with result stable until out_ready=1; that cycle FSM returns to IDLE and out_valid falls next cycle.
REQ-024 Latency: out_valid SHALL rise 2 cycles after the rising edge of the last operand handshake; 1 cycle after start for count=0.
REQ-025 With G=4 and count<=15 result SHALL equal the exact arithmetic sum (no overflow possible); for smaller G, result is the sum mod 2^R.
REQ-026 clr=1 SHALL force IDLE next cycle from any state, clear S, C, rem; result holds its value but out_valid=0; clr has priority over start and handshakes.
REQ-027 operand changing without handshake SHALL not affect state.

Reset
REQ-028 rst_n=0 SHALL immediately (no clock) force IDLE, S=C=0, rem=0, result=0, in_ready=0, out_valid=0, busy=0.
REQ-029 After rst_n rises, the first start SHALL be accepted on the first rising edge with rst_n=1.
REQ-030 Reset asserted mid-ACC or DONE SHALL discard the transaction; no partial result is presented.

Verification
REQ-031 count=3, operands 4'b1011, 4'b1101, 4'b0110 back-to-back -> result=8'h1E, out_valid 2 cycles after 3rd handshake.
REQ-032 count=3, operands 4'b1111, 4'b1111, 4'b0111 with in_valid low 2 cycles between each -> result=8'h25, in_ready stays 1 throughout ACC.
REQ-033 count=15, all operands 4'hF -> result=8'hE1, exact.
REQ-034 count=0 start -> out_valid=1 one cycle later, result=8'h00, in_ready never 1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> result and out_valid stable; start pulses during that time ignored.
REQ-036 rst_n pulsed low after 2 of 4 operands -> outputs zero without clock edge; new count=2 run {4'h3,4'h4} -> result=8'h07.
